// File: rtl/pfb_coef_loader.sv
// Coefficient load sequencer for the polyphase filter bank: streams prototype taps
// into the coefficient RAM, holds the datapath off while loading, then warms it up.
module pfb_coef_loader #(
    parameter int N      = 64,
    parameter int NT     = 8,
    parameter int B      = 16,
    parameter int WARMUP = 32,
    localparam int AW    = $clog2(N*NT),
    localparam int CW    = AW + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [B-1:0]  s_axis_tdata,
    input  logic          s_axis_tlast,
    output logic          coef_we,
    output logic [AW-1:0] coef_addr,
    output logic [B-1:0]  coef_data,
    output logic          pfb_en,
    output logic          busy,
    output logic          ready,
    output logic          err,
    output logic [CW-1:0] count
);
    localparam int WW = $clog2(WARMUP + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N*NT - 1);
    localparam logic [WW-1:0] WARM_END = WW'(WARMUP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_READY, S_ERR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [WW-1:0]   r_wcnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [B-1:0]    r_data;
    logic            w_acc;
    logic            w_load;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        pfb_en        = 1'b0;
        ready         = 1'b0;
        err           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = start;
            end
            S_LOAD: begin
                s_axis_tready = 1'b1;
                busy          = 1'b1;
                // The final-index beat must carry tlast, and tlast anywhere else is a framing error.
                if (s_axis_tvalid) begin
                    if (r_count == LAST_IDX) w_state_nxt = s_axis_tlast ? S_FLUSH : S_ERR;
                    else if (s_axis_tlast)   w_state_nxt = S_ERR;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                pfb_en = 1'b1;
                if (r_wcnt == WARM_END) w_state_nxt = S_READY;
            end
            S_READY: begin
                pfb_en = 1'b1;
                ready  = 1'b1;
                w_load = start;
            end
            S_ERR: begin
                err    = 1'b1;
                w_load = start;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) w_state_nxt = S_LOAD;
    end

    assign w_acc = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_count <= '0;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_we <= w_acc;
            if (w_acc) begin
                r_addr <= r_count[AW-1:0];
                r_data <= s_axis_tdata;
            end
            if (w_load)     r_count <= '0;
            else if (w_acc) r_count <= r_count + CW'(1);
            if (r_state == S_FLUSH) r_wcnt <= r_wcnt + WW'(1);
            else                    r_wcnt <= '0;
        end
    end

    assign coef_we   = r_we;
    assign coef_addr = r_addr;
    assign coef_data = r_data;
    assign count     = r_count;

endmodule

// File: tb/tb_pfb_coef_loader.sv
// Directed/randomized bench for pfb_coef_loader; expected writes and timing are derived
// from the beats the bench itself drives.
module tb_pfb_coef_loader;
    localparam int N = 64, NT = 8, B = 16, WARMUP = 32;
    localparam int TOT = N * NT;
    localparam int AW = $clog2(TOT);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic [B-1:0]  tdata = '0;
    logic          tready, coef_we, pfb_en, busy, ready, err;
    logic [AW-1:0] coef_addr;
    logic [B-1:0]  coef_data;
    logic [AW:0]   count;

    int nchk = 0;
    int nfail = 0;

    pfb_coef_loader #(.N(N), .NT(NT), .B(B), .WARMUP(WARMUP)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .s_axis_tlast(tlast), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .pfb_en(pfb_en), .busy(busy), .ready(ready),
        .err(err), .count(count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/ctl"}, {26'd0, tready, coef_we, pfb_en, busy, ready, err}, 32'd0);
        chk({tag, "/wr"}, {coef_addr, coef_data}, 32'd0);
        chk({tag, "/cnt"}, count, 32'd0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_pfb_en", pfb_en, 0);
        chk("start_tready", tready, 1);
        chk("start_busy", busy, 1);
        chk("start_ready", ready, 0);
        chk("start_err", err, 0);
        chk("start_cnt", count, 0);
    endtask

    // Drives nbeats beats; each must appear as a write one cycle after its handshake at addr k.
    task automatic run_load(input int nbeats, input int last_at, input int p_gap, input bit start_on_last);
        logic [B-1:0] d;
        for (int k = 0; k < nbeats; k++) begin
            while (int'($urandom_range(99)) < p_gap) begin
                tvalid = 1'b0;
                tdata  = B'($urandom);
                tlast  = 1'($urandom);
                cycle();
                chk("gap_we", coef_we, 0);
                chk("gap_cnt", count, k);
                chk("gap_tready", tready, 1);
            end
            d      = B'($urandom);
            tvalid = 1'b1;
            tdata  = d;
            tlast  = (k == last_at);
            start  = start_on_last && (k == nbeats - 1);
            cycle();
            chk("wr_we", coef_we, 1);
            chk("wr_addr", coef_addr, k);
            chk("wr_data", coef_data, d);
            chk("wr_cnt", count, k + 1);
            if (k < nbeats - 1) chk("load_busy", {tready, busy, pfb_en}, 3'b110);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        start  = 1'b0;
    endtask

    // Handshake edge was cycle 1; ready must first appear at cycle WARMUP+1.
    task automatic flush_check(input int start_at);
        bit exp_r;
        chk("flush1_ctl", {tready, busy, pfb_en, ready, err}, 5'b01100);
        for (int n = 2; n <= WARMUP + 4; n++) begin
            start  = (n == start_at);
            tvalid = 1'($urandom);
            cycle();
            start  = 1'b0;
            exp_r  = (n >= WARMUP + 1);
            chk("flush_ready", ready, exp_r);
            chk("flush_busy", busy, !exp_r);
            chk("flush_pfb_en", pfb_en, 1);
            chk("flush_tready", tready, 0);
            chk("flush_we", coef_we, 0);
            chk("flush_cnt", count, TOT);
        end
        tvalid = 1'b0;
    endtask

    task automatic err_check(input string tag, input int exp_cnt);
        chk({tag, "_ctl"}, {tready, busy, pfb_en, ready, err}, 5'b00001);
        chk({tag, "_cnt"}, count, exp_cnt);
        for (int n = 0; n < 5; n++) begin
            tvalid = 1'b1;
            tdata  = B'($urandom);
            cycle();
            chk({tag, "_hold_we"}, coef_we, 0);
            chk({tag, "_hold_cnt"}, count, exp_cnt);
            chk({tag, "_hold_err"}, {tready, err}, 2'b01);
        end
        tvalid = 1'b0;
    endtask

    initial begin
        #2;
        chk_all_zero("in_reset");
        #20;
        aresetn = 1'b1;
        // Idle: stray tvalid must not write.
        for (int n = 0; n < 100; n++) begin
            tvalid = 1'($urandom);
            tlast  = 1'($urandom);
            tdata  = B'($urandom);
            cycle();
            chk_all_zero("idle");
        end
        tvalid = 1'b0;
        tlast  = 1'b0;

        // Nominal load, start pulsed mid-flush.
        start_pulse();
        run_load(TOT, TOT - 1, 0, 1'b0);
        flush_check(10);

        // Reload from READY: pfb_en drops with the start edge; start on last beat and on last flush cycle ignored.
        start_pulse();
        run_load(TOT, TOT - 1, 50, 1'b1);
        flush_check(WARMUP + 1);

        // Early tlast, then recovery.
        start_pulse();
        run_load(101, 100, 30, 1'b0);
        err_check("early", 101);
        start_pulse();
        run_load(TOT, TOT - 1, 10, 1'b0);
        flush_check(0);

        // Missing tlast.
        start_pulse();
        run_load(TOT, -1, 20, 1'b0);
        err_check("missing", TOT);

        // Asynchronous reset in the middle of a load stops writes immediately.
        start_pulse();
        run_load(20, -1, 0, 1'b0);
        tvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        tvalid = 1'b0;
        #13;
        aresetn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk_all_zero("post_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
